// File: rtl/bram_bist_pkg.sv
// bram_bist_pkg: shared types and helpers for the BRAM March BIST.
//   state_e   - sequencer states
//   zero_pat  - all-zeros data background (truncate to the data width)
//   one_pat   - all-ones data background (truncate to the data width)
//   phase_len - number of addresses visited by one March phase
package bram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W0    = 3'd1,
    ST_R0W1  = 3'd2,
    ST_R1W0  = 3'd3,
    ST_RD0   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Widest data bus the pattern helpers support; callers cast down.
  localparam int unsigned PAT_MAX_W = 64;

  function automatic logic [PAT_MAX_W-1:0] zero_pat();
    return '0;
  endfunction

  function automatic logic [PAT_MAX_W-1:0] one_pat();
    return '1;
  endfunction

  function automatic int unsigned phase_len(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/bram_bist_chk.sv
// bram_bist_chk: read-compare pipeline and first-failure capture.
//   clk, reset_n      - clock, asynchronous active-low reset
//   clear_i           - drop any captured failure (new test accepted)
//   rd_en_i           - a read is being issued this cycle
//   exp_i, addr_i     - expected data and address of that read
//   mem_dout_i        - memory read data (valid one cycle after the read)
//   mismatch_o        - first mismatch seen this cycle
//   fail_o, fail_*_o  - sticky first-failure record
module bram_bist_chk #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              rd_en_i,
  input  logic [DWIDTH-1:0] exp_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] mem_dout_i,
  output logic              mismatch_o,
  output logic              fail_o,
  output logic [AWIDTH-1:0] fail_addr_o,
  output logic [DWIDTH-1:0] fail_exp_o,
  output logic [DWIDTH-1:0] fail_act_o
);

  logic              cmp_valid_q;
  logic [DWIDTH-1:0] cmp_exp_q;
  logic [AWIDTH-1:0] cmp_addr_q;
  logic              fail_q;
  logic [AWIDTH-1:0] fail_addr_q;
  logic [DWIDTH-1:0] fail_exp_q;
  logic [DWIDTH-1:0] fail_act_q;

  // Only the first mismatch counts; later ones are masked by fail_q.
  assign mismatch_o = cmp_valid_q && (mem_dout_i != cmp_exp_q) && !fail_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      // Free-running one-stage pipeline: no bubbles at phase changes.
      cmp_valid_q <= rd_en_i;
      cmp_exp_q   <= exp_i;
      cmp_addr_q  <= addr_i;
      if (clear_i) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_act_q  <= '0;
      end else if (mismatch_o) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr_q;
        fail_exp_q  <= cmp_exp_q;
        fail_act_q  <= mem_dout_i;
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_act_o  = fail_act_q;

endmodule

// File: rtl/bram_bist.sv
// bram_bist: March (W0, R0W1, R1W0, RD0) self-test sequencer for a BRAM
// with registered, read-before-write output.
//   clk, reset_n       - clock, asynchronous active-low reset
//   start              - test request (rising edge, accepted in IDLE/DONE)
//   busy, done         - test running / finished (done held until restart)
//   fail, fail_*       - first mismatch address, expected and actual data
//   mem_we, mem_wr_addr, mem_din, mem_rd_addr - memory drive
//   mem_dout           - memory read data, one cycle latency
module bram_bist
  import bram_bist_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [DWIDTH-1:0] fail_exp,
  output logic [DWIDTH-1:0] fail_act,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_wr_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic [AWIDTH-1:0] mem_rd_addr,
  input  logic [DWIDTH-1:0] mem_dout
);

  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(phase_len(AWIDTH) - 1);
  localparam logic [DWIDTH-1:0] ZERO      = DWIDTH'(zero_pat());
  localparam logic [DWIDTH-1:0] ONE       = DWIDTH'(one_pat());

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              start_prev_q;
  logic              start_req;
  logic              mismatch;
  logic              rd_en;
  logic              clear;
  logic [DWIDTH-1:0] exp_pat;

  // Edge-qualified start: a request held high across a whole run does not
  // retrigger once DONE is reached.
  assign start_req = start && !start_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      start_prev_q <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          state_d = ST_W0;
          addr_d  = '0;
        end
      end
      ST_W0: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) state_d = ST_R0W1;
      end
      ST_R0W1: begin
        // Hold the top address: R1W0 starts where R0W1 ends.
        if (addr_q == ADDR_LAST) state_d = ST_R1W0;
        else                     addr_d  = addr_q + 1'b1;
      end
      ST_R1W0: begin
        if (addr_q == '0) state_d = ST_RD0;
        else              addr_d  = addr_q - 1'b1;
      end
      ST_RD0: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (mismatch && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    mem_din     = ZERO;
    exp_pat     = ZERO;
    case (state_q)
      ST_W0: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      ST_R0W1: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        rd_en   = 1'b1;
        mem_din = ONE;
      end
      ST_R1W0: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        rd_en   = 1'b1;
        exp_pat = ONE;
      end
      ST_RD0: begin
        busy  = 1'b1;
        rd_en = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
    mem_wr_addr = mem_we ? addr_q : '0;
    mem_rd_addr = rd_en  ? addr_q : '0;
    clear       = start_req && (state_q == ST_IDLE || state_q == ST_DONE);
  end

  bram_bist_chk #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear),
    .rd_en_i     (rd_en),
    .exp_i       (exp_pat),
    .addr_i      (addr_q),
    .mem_dout_i  (mem_dout),
    .mismatch_o  (mismatch),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_exp_o  (fail_exp),
    .fail_act_o  (fail_act)
  );

endmodule

// File: tb/tb_bram_bist.sv
module tb_bram_bist;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int N  = 1 << AW;
  localparam logic [DW-1:0] ONES = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start;
  logic          busy, done, fail, mem_we;
  logic [AW-1:0] fail_addr, mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] fail_exp, fail_act, mem_din, mem_dout;

  // Memory with an optional single stuck-at bit in one cell.
  logic [DW-1:0] mem [N];
  logic          flt_en;
  int            flt_addr, flt_bit;
  logic          flt_val;

  int checks = 0;
  int errors = 0;

  bram_bist #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
    .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout)
  );

  function automatic logic [DW-1:0] stuck(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = DW'(1) << flt_bit;
    if (flt_en && a == flt_addr) return flt_val ? (v | m) : (v & ~m);
    return v;
  endfunction

  always @(posedge clk) begin
    mem_dout <= mem[mem_rd_addr];
    if (mem_we) mem[mem_wr_addr] <= stuck(int'(mem_wr_addr), mem_din);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string         name;
    logic          fail;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
    logic [DW-1:0] act;
    int            busy_cycles;
    int            writes;
  } exp_t;
  exp_t sb[$];

  // Reference: walk the March element list over an abstract array and find
  // the first read that disagrees with its background. A read in test
  // cycle s is judged in cycle s+1, after which the test stops.
  task automatic predict_and_push(input string name);
    logic [DW-1:0] r [N];
    exp_t e;
    int   step;
    bit   found;
    e.name = name; e.fail = 1'b0; e.addr = '0; e.exp = '0; e.act = '0;
    e.busy_cycles = 4 * N + 1; e.writes = 3 * N;
    step = 0; found = 0;
    for (int a = 0; a < N; a++) begin
      r[a] = stuck(a, '0); step++;
    end
    for (int a = 0; a < N; a++) if (!found) begin
      if (r[a] != '0) begin
        found = 1; e.addr = AW'(a); e.exp = '0; e.act = r[a]; e.busy_cycles = step + 2;
      end else r[a] = stuck(a, ONES);
      step++;
    end
    for (int a = N - 1; a >= 0; a--) if (!found) begin
      if (r[a] != ONES) begin
        found = 1; e.addr = AW'(a); e.exp = ONES; e.act = r[a]; e.busy_cycles = step + 2;
      end else r[a] = stuck(a, '0);
      step++;
    end
    for (int a = 0; a < N; a++) if (!found) begin
      if (r[a] != '0) begin
        found = 1; e.addr = AW'(a); e.exp = '0; e.act = r[a]; e.busy_cycles = step + 2;
      end
      step++;
    end
    if (found) begin
      e.fail   = 1'b1;
      e.writes = (e.busy_cycles < 3 * N) ? e.busy_cycles : 3 * N;
    end
    sb.push_back(e);
  endtask

  // Monitor: counts busy cycles and writes, checks write protocol, and
  // scores each completed run against the queued prediction.
  initial begin
    int   busy_cnt, wr_cnt;
    bit   proto_bad;
    logic done_prev;
    exp_t e;
    busy_cnt = 0; wr_cnt = 0; proto_bad = 0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0; wr_cnt = 0; proto_bad = 0; done_prev = 1'b0;
      end else begin
        if (mem_we) begin
          if (done || !busy) proto_bad = 1;
          if (wr_cnt >= N && mem_rd_addr != mem_wr_addr) proto_bad = 1;
          wr_cnt++;
        end
        if (busy) busy_cnt++;
        if (done && !done_prev) begin
          chk("sb_has_entry", 64'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("RUN %s fail=%0b addr=%0d exp=%0h act=%0h busy=%0d writes=%0d",
                     e.name, fail, fail_addr, fail_exp, fail_act, busy_cnt, wr_cnt);
            chk({e.name, "_fail"},     fail,      e.fail);
            chk({e.name, "_addr"},     fail_addr, e.addr);
            chk({e.name, "_exp"},      fail_exp,  e.exp);
            chk({e.name, "_act"},      fail_act,  e.act);
            chk({e.name, "_busy"},     busy_cnt,  e.busy_cycles);
            chk({e.name, "_writes"},   wr_cnt,    e.writes);
            chk({e.name, "_protocol"}, proto_bad, 0);
          end
          busy_cnt = 0; wr_cnt = 0; proto_bad = 0;
        end
        done_prev = done;
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_done_seen"}, done, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input string name);
    predict_and_push(name);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0;
    flt_en = 1'b0; flt_addr = 0; flt_bit = 0; flt_val = 1'b0;
    #3;
    chk("reset_outputs", {busy, done, fail, mem_we, fail_addr, fail_exp, fail_act,
                          mem_wr_addr, mem_rd_addr, mem_din}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run("pass");

    flt_en = 1'b1; flt_addr = 2; flt_bit = 3; flt_val = 1'b1;
    run("sa1_a2_b3");
    flt_en = 1'b1; flt_addr = 3; flt_bit = 0; flt_val = 1'b0;
    run("sa0_a3_b0");

    // Abort a run with reset; outputs must clear without a clock edge.
    flt_en = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {busy, done, fail, mem_we, fail_addr, fail_exp, fail_act,
                              mem_wr_addr, mem_rd_addr, mem_din}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    run("after_reset");

    // start held through a whole run: exactly one run, then a fresh start.
    flt_en = 1'b1; flt_addr = 1; flt_bit = 5; flt_val = 1'b1;
    predict_and_push("held");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    chk("held_started", busy, 1);
    wait_done("held");
    repeat (6) @(posedge clk);
    #1;
    chk("held_no_restart", busy, 0);
    chk("held_done_level", {done, fail}, 2'b11);
    start = 1'b0;
    flt_en = 1'b0;
    predict_and_push("restart");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_clear", {done, fail, fail_addr, fail_exp, fail_act}, 0);
    chk("restart_busy", busy, 1);
    wait_done("restart");

    for (int i = 0; i < 10; i++) begin
      flt_en   = ($urandom_range(0, 2) != 0);
      flt_addr = int'($urandom_range(0, N - 1));
      flt_bit  = int'($urandom_range(0, DW - 1));
      flt_val  = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
